// File: rtl/ysyx_25020047_arb_pkg.sv
// ysyx_25020047_arb_pkg: shared encodings and constants for the IFU/LSU memory arbiter
//   ST_*      : sequencer states (IDLE, ISSUE, WAIT)
//   OWN_*     : which requester owns the outstanding transaction
//   wd_width  : watchdog counter width, clog2(TIMEOUT+1), never below 1 bit
package ysyx_25020047_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IFU  = 2'd1;
    localparam logic [1:0] OWN_LSU  = 2'd2;

    localparam int DEF_TIMEOUT = 255;

    function automatic int wd_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/ysyx_25020047_arb_pick.sv
// ysyx_25020047_arb_pick: combinational winner select between IFU and LSU
//   ifu_valid, lsu_valid : pending requests
//   rr                   : round-robin pointer, 0 = IFU next, 1 = LSU next (ARB_RR_EN only)
//   grant                : one-hot {lsu, ifu}
// ARB_RR_EN defined selects round-robin on contention; otherwise LSU has fixed priority.
module ysyx_25020047_arb_pick
    import ysyx_25020047_arb_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
`ifdef ARB_RR_EN
    input  logic       rr,
`endif
    output logic [1:0] grant
);

`ifdef ARB_RR_EN
    always_comb grant = (ifu_valid && lsu_valid) ? (rr ? 2'b10 : 2'b01) : {lsu_valid, ifu_valid};
`else
    always_comb grant = lsu_valid ? 2'b10 : {1'b0, ifu_valid};
`endif

endmodule

// File: rtl/ysyx_25020047_mem_arb.sv
// ysyx_25020047_mem_arb: serialises IFU and LSU requests onto one memory port, one transaction at a time
//   clk, rst (sync, active-low)
//   ifu_req_*/ifu_resp_*/ifu_rdata : instruction fetch port (read only)
//   lsu_req_*/lsu_resp_*/lsu_rdata, lsu_wen/addr/wdata/wmask : load/store port
//   mem_req_*/mem_resp_*, mem_wen/addr/wdata/wmask, mem_rdata : shared memory port
//   busy : a transaction is in flight
// ARB_RR_EN defined enables round-robin arbitration (default: LSU > IFU).
module ysyx_25020047_mem_arb
    import ysyx_25020047_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_resp_valid,
    output logic [DW-1:0] ifu_rdata,
    output logic          ifu_resp_err,
    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic          lsu_wen,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [3:0]    lsu_wmask,
    output logic          lsu_resp_valid,
    output logic [DW-1:0] lsu_rdata,
    output logic          lsu_resp_err,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_wmask,
    input  logic          mem_resp_valid,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int WW = wd_width(TIMEOUT);

    logic [1:0]    state;
    logic [1:0]    owner;
    logic [WW-1:0] wd;
    logic [1:0]    grant;
    logic          idle;
    logic          expire;
    logic          finish;

`ifdef ARB_RR_EN
    logic rr;
`endif

    ysyx_25020047_arb_pick u_pick (
        .ifu_valid (ifu_req_valid),
        .lsu_valid (lsu_req_valid),
`ifdef ARB_RR_EN
        .rr        (rr),
`endif
        .grant     (grant)
    );

    assign idle          = state == ST_IDLE;
    assign busy          = !idle;
    assign ifu_req_ready = idle && grant[0];
    assign lsu_req_ready = idle && grant[1];
    assign mem_req_valid = state == ST_ISSUE;
    // A response in the expiry cycle takes precedence over the error.
    assign expire        = (TIMEOUT != 0) && (wd == WW'(TIMEOUT - 1));
    assign finish        = mem_resp_valid || expire;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            owner          <= OWN_NONE;
            wd             <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_resp_err   <= 1'b0;
            ifu_rdata      <= '0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_err   <= 1'b0;
            lsu_rdata      <= '0;
            mem_wen        <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
        end else begin
            ifu_resp_valid <= 1'b0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        state     <= ST_ISSUE;
                        owner     <= grant[1] ? OWN_LSU : OWN_IFU;
                        mem_wen   <= grant[1] && lsu_wen;
                        mem_addr  <= grant[1] ? lsu_addr : ifu_addr;
                        mem_wdata <= grant[1] ? lsu_wdata : '0;
                        mem_wmask <= grant[1] ? lsu_wmask : 4'b0000;
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready) begin
                        state <= ST_WAIT;
                        wd    <= '0;
                    end
                end
                ST_WAIT: begin
                    if (finish) begin
                        state <= ST_IDLE;
                        owner <= OWN_NONE;
                        if (owner == OWN_LSU) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_resp_err   <= !mem_resp_valid;
                            lsu_rdata      <= (mem_resp_valid && !mem_wen) ? mem_rdata : '0;
                        end
                        if (owner == OWN_IFU) begin
                            ifu_resp_valid <= 1'b1;
                            ifu_resp_err   <= !mem_resp_valid;
                            ifu_rdata      <= mem_resp_valid ? mem_rdata : '0;
                        end
                    end else if (TIMEOUT != 0 && wd != '1) begin
                        wd <= wd + WW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ARB_RR_EN
    // Pointer flips to whichever requester was not just served.
    always_ff @(posedge clk) begin
        if (!rst)
            rr <= 1'b0;
        else if (idle && grant != 2'b00)
            rr <= grant[0];
    end
`endif

endmodule

// File: tb/tb_ysyx_25020047_mem_arb.sv
// tb_ysyx_25020047_mem_arb: directed bench with a transaction-level reference model for the memory arbiter
module tb_ysyx_25020047_mem_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ifu_req_valid = 1'b0;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_addr = '0;
    logic          ifu_resp_valid;
    logic [DW-1:0] ifu_rdata;
    logic          ifu_resp_err;
    logic          lsu_req_valid = 1'b0;
    logic          lsu_req_ready;
    logic          lsu_wen = 1'b0;
    logic [AW-1:0] lsu_addr = '0;
    logic [DW-1:0] lsu_wdata = '0;
    logic [3:0]    lsu_wmask = '0;
    logic          lsu_resp_valid;
    logic [DW-1:0] lsu_rdata;
    logic          lsu_resp_err;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    ysyx_25020047_mem_arb #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory responder: ready after rdy_lat ISSUE cycles, response after rsp_lat WAIT cycles (-1 = never).
    int            rdy_lat = 0;
    int            rsp_lat = 0;
    int            issue_cyc = 0;
    int            wait_cyc = 0;
    logic [DW-1:0] rdata_val = '0;
    logic          inject = 1'b0;

    initial begin
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_req_ready = mem_req_valid && issue_cyc >= rdy_lat;
            issue_cyc = mem_req_valid ? issue_cyc + 1 : 0;
            mem_resp_valid = inject || (busy && !mem_req_valid && rsp_lat >= 0 && wait_cyc == rsp_lat);
            wait_cyc = (busy && !mem_req_valid) ? wait_cyc + 1 : 0;
            mem_rdata = mem_resp_valid ? rdata_val : ~rdata_val;
        end
    end

    // Reference model: one pending transaction record plus the last delivered results per port.
    bit            chk_en = 1'b0;
    bit            m_busy = 1'b0;
    bit            m_acc = 1'b0;
    int            m_own = 0;
    int            m_waited = 0;
    bit            m_rr = 1'b0;
    logic          m_wen = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [3:0]    m_wmask = '0;
    bit            m_irv = 1'b0, m_ierr = 1'b0, m_lrv = 1'b0, m_lerr = 1'b0;
    logic [DW-1:0] m_ird = '0, m_lrd = '0;

    function automatic int pick(input bit iv, input bit lv, input bit rr);
        if (iv && lv) return RR ? (rr ? 2 : 1) : 2;
        return lv ? 2 : (iv ? 1 : 0);
    endfunction

    task automatic deliver(input bit err, input logic [DW-1:0] d);
        if (m_own == 1) begin
            m_irv = 1'b1; m_ierr = err; m_ird = d;
        end else begin
            m_lrv = 1'b1; m_lerr = err; m_lrd = d;
        end
        m_busy = 1'b0;
        m_own = 0;
    endtask

    always @(negedge clk) if (chk_en) begin
        int g;
        g = m_busy ? 0 : pick(ifu_req_valid, lsu_req_valid, m_rr);
        chk("busy", busy, m_busy);
        chk("ifu_req_ready", ifu_req_ready, g == 1);
        chk("lsu_req_ready", lsu_req_ready, g == 2);
        chk("mem_req_valid", mem_req_valid, m_busy && !m_acc);
        chk("mem_wen", mem_wen, m_wen);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_wmask", mem_wmask, m_wmask);
        chk("ifu_resp_valid", ifu_resp_valid, m_irv);
        chk("ifu_resp_err", ifu_resp_err, m_ierr);
        chk("ifu_rdata", ifu_rdata, m_ird);
        chk("lsu_resp_valid", lsu_resp_valid, m_lrv);
        chk("lsu_resp_err", lsu_resp_err, m_lerr);
        chk("lsu_rdata", lsu_rdata, m_lrd);
        m_irv = 1'b0; m_ierr = 1'b0; m_lrv = 1'b0; m_lerr = 1'b0;
        if (!rst) begin
            m_busy = 1'b0; m_acc = 1'b0; m_own = 0; m_waited = 0; m_rr = 1'b0;
            m_wen = 1'b0; m_addr = '0; m_wdata = '0; m_wmask = '0; m_ird = '0; m_lrd = '0;
        end else if (!m_busy) begin
            if (g != 0) begin
                m_busy = 1'b1; m_acc = 1'b0; m_own = g; m_rr = (g == 1);
                m_wen = (g == 2) && lsu_wen;
                m_addr = (g == 2) ? lsu_addr : ifu_addr;
                m_wdata = (g == 2) ? lsu_wdata : '0;
                m_wmask = (g == 2) ? lsu_wmask : 4'b0000;
            end
        end else if (!m_acc) begin
            if (mem_req_ready) begin
                m_acc = 1'b1; m_waited = 0;
            end
        end else if (mem_resp_valid) begin
            deliver(1'b0, (m_own == 2 && m_wen) ? '0 : mem_rdata);
        end else if (TO != 0 && m_waited + 1 == TO) begin
            deliver(1'b1, '0);
        end else begin
            m_waited++;
        end
    end

    // Snapshots taken mid-cycle by the directed sequence.
    bit            s_ir, s_lr, s_hi, s_hl, s_irv, s_lrv, s_ierr, s_lerr, s_mrv, s_mrdy;
    logic [DW-1:0] s_ird, s_lrd;

    task automatic cyc;
        @(negedge clk);
        s_ir = ifu_req_ready; s_lr = lsu_req_ready;
        s_hi = ifu_req_valid && ifu_req_ready;
        s_hl = lsu_req_valid && lsu_req_ready;
        s_irv = ifu_resp_valid; s_lrv = lsu_resp_valid;
        s_ierr = ifu_resp_err; s_lerr = lsu_resp_err;
        s_ird = ifu_rdata; s_lrd = lsu_rdata;
        s_mrv = mem_req_valid; s_mrdy = mem_req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input bit lsu, output int n, output bit other);
        n = -1;
        other = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            other |= lsu ? s_irv : s_lrv;
            if (lsu ? s_lrv : s_irv) begin
                n = k;
                break;
            end
        end
    endtask

    int n;
    bit other;
    int il, ll, ng;
    int order[4];

    initial begin
        repeat (2) cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_busy", busy, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_ifu_rdata", ifu_rdata, 0);
        chk("rst_lsu_rdata", lsu_rdata, 0);
        chk("rst_ifu_resp_valid", ifu_resp_valid, 0);

        // IFU-only fetch
        rst = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; rdata_val = 32'h0000_0413;
        cyc();
        chk("s1_ifu_ready", s_ir, 1);
        chk("s1_lsu_ready", s_lr, 0);
        ifu_req_valid = 1'b0;
        wait_resp(1'b0, n, other);
        chk("s1_latency", n, 3);
        chk("s1_ifu_rdata", s_ird, 32'h0000_0413);
        chk("s1_ifu_err", s_ierr, 0);
        chk("s1_lsu_quiet", other, 0);
        cyc();
        chk("s1_pulse_one_cycle", s_irv, 0);
        chk("s1_rdata_hold", s_ird, 32'h0000_0413);

        // Contention after a fresh reset
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        rdata_val = 32'h1111_2222;
        ifu_addr = 32'h8000_0004; lsu_wen = 1'b0; lsu_addr = 32'h8000_0100;
        il = RR ? 2 : 1; ll = RR ? 2 : 1; ng = 0;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        for (int k = 0; k < 80 && (il > 0 || ll > 0 || busy); k++) begin
            cyc();
            if (k == 0) begin
                chk("s2_first_ifu_ready", s_ir, RR);
                chk("s2_first_lsu_ready", s_lr, !RR);
            end
            if (s_hi && ng < 4) begin
                order[ng] = 1; ng++; il--;
                if (il == 0) ifu_req_valid = 1'b0;
                if (!RR) chk("s2_ifu_grant_in_lsu_resp_cycle", s_lrv, 1);
            end
            if (s_hl && ng < 4) begin
                order[ng] = 2; ng++; ll--;
                if (ll == 0) lsu_req_valid = 1'b0;
            end
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        chk("s2_grants", ng, RR ? 4 : 2);
        chk("s2_order0", order[0], RR ? 1 : 2);
        chk("s2_order1", order[1], RR ? 2 : 1);
        if (RR) begin
            chk("s2_order2", order[2], 1);
            chk("s2_order3", order[3], 2);
        end
        cyc();
        chk("s2_ifu_rdata", s_ird, 32'h1111_2222);

        // Store held in ISSUE for 5 cycles
        rdy_lat = 5; rdata_val = 32'hcafe_f00d;
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hdead_beef; lsu_wmask = 4'b0011;
        cyc();
        chk("s3_handshake", s_hl, 1);
        lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = 4'hf;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("s3_mem_req_valid", s_mrv, 1);
            chk("s3_mem_req_ready", s_mrdy, 0);
            chk("s3_mem_wen", mem_wen, 1);
            chk("s3_mem_addr", mem_addr, 32'h8000_1000);
            chk("s3_mem_wdata", mem_wdata, 32'hdead_beef);
            chk("s3_mem_wmask", mem_wmask, 4'b0011);
        end
        wait_resp(1'b1, n, other);
        chk("s3_done_after_accept", n, 3);
        chk("s3_store_rdata", s_lrd, 0);
        chk("s3_store_err", s_lerr, 0);
        chk("s3_ifu_quiet", other, 0);

        // Response lands in the watchdog's final cycle: normal completion
        rdy_lat = 0; rsp_lat = 3; rdata_val = 32'h5a5a_5a5a;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000;
        cyc();
        lsu_req_valid = 1'b0;
        wait_resp(1'b1, n, other);
        chk("s4_race_latency", n, 6);
        chk("s4_race_err", s_lerr, 0);
        chk("s4_race_rdata", s_lrd, 32'h5a5a_5a5a);

        // Memory never answers: error after 4 WAIT cycles
        rsp_lat = -1;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2004;
        cyc();
        lsu_req_valid = 1'b0;
        wait_resp(1'b1, n, other);
        chk("s4_timeout_latency", n, 6);
        chk("s4_timeout_err", s_lerr, 1);
        chk("s4_timeout_rdata", s_lrd, 0);
        inject = 1'b1; rdata_val = 32'h7777_7777;
        cyc();
        inject = 1'b0;
        cyc();
        cyc();
        chk("s4_idle_resp_ignored_lsu", s_lrv, 0);
        chk("s4_idle_resp_ignored_ifu", s_irv, 0);
        chk("s4_idle_rdata_hold", s_lrd, 0);
        chk("s4_idle_busy", busy, 0);

        // Reset while waiting drops the fetch silently
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
        cyc();
        ifu_req_valid = 1'b0;
        cyc();
        cyc();
        chk("s5_in_wait", busy, 1);
        rst = 1'b0;
        cyc();
        chk("s5_busy", busy, 0);
        chk("s5_mem_req_valid", mem_req_valid, 0);
        chk("s5_no_resp", ifu_resp_valid, 0);
        chk("s5_rdata_cleared", ifu_rdata, 0);
        rst = 1'b1;
        cyc();
        chk("s5_no_late_resp", s_irv, 0);
        rsp_lat = 0; rdata_val = 32'h0000_0517;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_000c;
        cyc();
        ifu_req_valid = 1'b0;
        wait_resp(1'b0, n, other);
        chk("s5_recover_latency", n, 3);
        chk("s5_recover_rdata", s_ird, 32'h0000_0517);
        chk("s5_recover_err", s_ierr, 0);

        repeat (2) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got hang, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ysyx_25020047_mem_arb.md
Name: ysyx_25020047_mem_arb

Overview:
- Single-port memory arbiter and sequencer sharing one memory interface between the IFU (instruction fetch) and the LSU (load/store).
- Replaces direct per-unit DPI calls: IFU and LSU issue valid/ready requests, and the arbiter serialises them onto one memory port.
- One transaction is outstanding at a time, with a response watchdog.
- Sits between the IFU/LSU and the memory model (DPI-backed pmem adapter), in front of the multi-cycle NPC core.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 255, cycles to wait in WAIT before forcing an error response. 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  AW  fetch address
- ifu_resp_valid  out  1  one-cycle pulse, fetch data valid
- ifu_rdata  out  DW  fetched instruction
- ifu_resp_err  out  1  fetch timed out
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted
- lsu_wen  in  1  1 = store, 0 = load
- lsu_addr  in  AW  access address
- lsu_wdata  in  DW  store data
- lsu_wmask  in  4  byte-lane write mask
- lsu_resp_valid  out  1  one-cycle pulse, load data / store done
- lsu_rdata  out  DW  load data (0 for stores)
- lsu_resp_err  out  1  access timed out
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_wen, mem_addr, mem_wdata, mem_wmask  out  1/AW/DW/4  latched request fields
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DW  memory read data
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT.
- Reset (rst == 0 at a clk edge) forces:
  - state = IDLE, owner = NONE;
  - all resp_valid/resp_err = 0, rdata outputs = 0, mem_* request fields = 0;
  - watchdog = 0, rr pointer = IFU.
- Reset mid-transaction drops the transaction with no response. A mem_resp_valid received while in IDLE is ignored.
- IDLE:
  - Winner chosen combinationally from the valids. Default: LSU has fixed priority over IFU.
  - Only the winner's req_ready = 1; the loser's ready = 0.
  - On handshake: latch wen/addr/wdata/wmask (IFU: wen = 0, wmask = 0), record owner, go to ISSUE.
- ISSUE:
  - mem_req_valid = 1 with latched fields; fields are stable until accepted.
  - On mem_req_ready: go to WAIT, clear watchdog.
  - No requester ready is asserted in ISSUE or WAIT.
- WAIT:
  - On mem_resp_valid: register mem_rdata into the owner's rdata (LSU store: rdata = 0), pulse the owner's resp_valid for one cycle on the next edge, return to IDLE.
  - Else, if TIMEOUT != 0, increment watchdog. When watchdog == TIMEOUT-1 with no response: pulse owner resp_valid with resp_err = 1 and rdata = 0, return to IDLE.
  - A response arriving in the same cycle as expiry wins: normal response, err = 0.
- Latency:
  - Minimum from request handshake to resp_valid is 3 edges (handshake → ISSUE → WAIT → resp), given mem_req_ready = 1 in ISSUE and mem_resp_valid in the first WAIT cycle.
- Back-to-back:
  - The resp pulse cycle is already IDLE, so a new request may handshake in the same cycle the previous response is delivered.
- Output stability:
  - rdata holds its last value until the next response for that port.
  - resp_valid is never asserted for the non-owner.
- Widths:
  - Watchdog counter is clog2(TIMEOUT+1) bits and saturates.
  - Fields pass through unmodified; no address alignment checks.

Optional Feature:
- ARB_RR_EN defined: round-robin arbitration.
  - On simultaneous valids in IDLE, grant the requester the rr pointer selects.
  - After each grant, the rr pointer moves to the other requester.
  - A single requester is always granted.
- ARB_RR_EN undefined: fixed priority, LSU > IFU; rr pointer logic absent.

Decomposition:
- Package ysyx_25020047_arb_pkg:
  - state encoding (IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2);
  - owner encoding (NONE = 2'd0, IFU = 2'd1, LSU = 2'd2);
  - default TIMEOUT constant.
- Sub-module ysyx_25020047_arb_pick: combinational winner select (fixed / RR under ARB_RR_EN), inputs valids + rr pointer, output one-hot grant.

Test Plan:
- IFU only: ifu_addr = 0x80000000, memory returns 0x00000413 after 1 cycle → ifu_resp_valid pulses 3 edges after handshake, ifu_rdata = 0x00000413, lsu_resp_valid stays 0.
- Simultaneous IFU and LSU valid, ARB_RR_EN undefined → LSU granted first (lsu_req_ready = 1, ifu_req_ready = 0); IFU granted in the cycle LSU's response pulses.
- Same stimulus with ARB_RR_EN, held for 4 transactions → grant order IFU, LSU, IFU, LSU.
- LSU store: addr 0x80001000, wdata 0xdeadbeef, wmask 4'b0011 → mem_* fields match exactly while mem_req_valid is held with mem_req_ready = 0 for 5 cycles; lsu_rdata = 0 on completion.
- TIMEOUT = 4, memory never responds → lsu_resp_err = 1, lsu_resp_valid pulse after 4 WAIT cycles; a later mem_resp_valid in IDLE is ignored.
- rst driven to 0 during WAIT → next cycle busy = 0, no resp pulse, mem_req_valid = 0; a new IFU request after release completes normally.
